note_detector: RTL and testbench
================================

Name: note_detector

Overview:
- Receiving end of the note sequencer: listens to a single-channel square-wave tone (DO/RE/MI/silence) and decodes which note is playing.
- Measures the input period in system clocks between rising edges and matches it against the note periods from divider.vh.
- Reports a 2-bit note code plus a one-cycle change strobe.
- Sits at an input pin (e.g. loopback from the sequencer's ch_out) and drives LEDs or downstream logic.

Parameters:
- N0, `DO_4, period of note 0 in clk cycles
- N1, `RE_4, period of note 1 in clk cycles
- N2, `MI_4, period of note 2 in clk cycles
- TOL, 256, accepted ± deviation in cycles from each Nx
- TIMEOUT, 100000, cycles without a rising edge before declaring silence; must exceed max(Nx)+TOL
- CW, 17, period counter width; 2^CW-1 ≥ TIMEOUT

Ports:
- clk  in  1  system clock (12 MHz)
- rst  in  1  synchronous, active-high reset
- ch_in  in  1  asynchronous tone input
- note  out  2  0=N0, 1=N1, 2=N2, 3=silence/unknown
- note_chg  out  1  one-cycle pulse when note changes value

Behaviour:
- Reset (rst=1 at clk edge): note=3, note_chg=0, counter=0, state=SILENT, candidate=3, matchcnt=0. Reset mid-measurement discards any partial period.
- Input path: 2-flop synchronizer, then rising-edge detect. ch_in rising edge → internal edge pulse 3 clk later.
- Period counter: increments every clk, saturates at TIMEOUT, and clears to 1 on an edge pulse (the edge cycle counts as cycle 0 of the new period).
- Classification on each edge pulse: class = k if |counter − Nk| ≤ TOL; else 3. Lowest k wins if ranges overlap. Use unsigned compare with both bounds precomputed as constants; no signed arithmetic.
- FSM states:
  - SILENT: on an edge pulse → ARMED, counter cleared; no classification, since the first edge has no prior reference.
  - ARMED/TRACK: on an edge pulse, classify. If class == candidate, matchcnt++ (saturating at 2); else candidate=class, matchcnt=1. ARMED → TRACK after the first classification.
  - Any state: counter reaching TIMEOUT → SILENT, candidate=3, matchcnt=0.
- Debounce: note takes candidate only when matchcnt reaches 2, i.e. two consecutive matching periods. Update happens in the cycle after the qualifying edge pulse. Unknown periods (class 3) also need two in a row before note=3.
- Silence: entering SILENT from TIMEOUT forces note=3 in the same cycle as the transition.
- note_chg: asserted exactly one cycle, in the cycle note takes a new value. Never asserted if the new value equals the old. Never asserted by reset.
- Simultaneous edge and TIMEOUT in the same cycle: the edge wins; counter clears and the timeout is ignored.
- Glitches shorter than 1 clk may be missed; no filtering beyond the synchronizer.

Optional Feature:
- Macro NOTEDET_PERIOD_OUT_EN.
- When defined: extra output port period [CW-1:0] holds the last completed period measured at an edge pulse in ARMED/TRACK. Reset value 0; loaded in the same cycle the classification is made. Unchanged on TIMEOUT.
- When undefined: the port and its register do not exist. All other behaviour is identical.

Decomposition:
- Shared header notedet.vh: note code constants NOTE_0=0, NOTE_1=1, NOTE_2=2, NOTE_SIL=3, and FSM state encodings.
- Note period constants come from the existing divider.vh.
- One sub-module, edge_sync: 2-flop synchronizer plus rising-edge pulse. Ports clk, rst, d_in, rise; reset clears all flops.

Test Plan (bench overrides N0=20, N1=16, N2=12, TOL=1, TIMEOUT=64, CW=7):
- Reset held 3 cycles, ch_in idle → note=3, note_chg=0 throughout.
- Square wave, period 20 cycles, 5 periods → note=0. note_chg pulses once, one cycle after the 3rd internal edge pulse (two matched periods).
- Period 20 then switch to period 12 → note stays 0 for one 12-cycle period, then becomes 2 with a single note_chg pulse. Period 13 (within TOL) yields the same result.
- Period 16 then ch_in held low → note goes 1 → 3, 64 cycles after the last edge pulse, with a note_chg pulse at that point.
- Period 18 (outside all windows) for 3 periods after note=0 → note=3 after two unknown periods. Alternating 20/18 never reaches note=3 and never re-pulses note=0.
- rst asserted mid-period during note=1 → next cycle note=3, state SILENT. Note=1 is recovered only after 3 fresh edges. With NOTEDET_PERIOD_OUT_EN defined, period reads 0 after reset and 16 after the first classified edge.

Source files
------------

// File: rtl/note_detector_pkg.sv
// Shared constants for the note detector: note codes, FSM encodings, default note periods.
// Periods are 12 MHz clock counts for C4/D4/E4 tones.
package note_detector_pkg;

  localparam int DO_4 = 45867;
  localparam int RE_4 = 40863;
  localparam int MI_4 = 36404;

  typedef logic [1:0] note_t;

  localparam note_t NOTE_0   = 2'd0;
  localparam note_t NOTE_1   = 2'd1;
  localparam note_t NOTE_2   = 2'd2;
  localparam note_t NOTE_SIL = 2'd3;

  localparam logic [1:0] ST_SILENT = 2'd0;
  localparam logic [1:0] ST_ARMED  = 2'd1;
  localparam logic [1:0] ST_TRACK  = 2'd2;

endpackage

// File: rtl/note_detector_edge_sync.sv
// Two-flop synchronizer plus rising-edge detect; rise is acted on at the third clk edge after d_in rises.
// No backpressure: a one-cycle pulse per synchronized rising edge.
module edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic d_in,
  output logic rise
);

  logic s1, s2, s3;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= d_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

endmodule

// File: rtl/note_detector.sv
// Decodes DO/RE/MI/silence from a square-wave tone by period measurement, two-period debounce.
// note updates one cycle after the qualifying edge pulse; optional period output via NOTEDET_PERIOD_OUT_EN.
module note_detector
  import note_detector_pkg::*;
#(
  parameter int N0      = DO_4,
  parameter int N1      = RE_4,
  parameter int N2      = MI_4,
  parameter int TOL     = 256,
  parameter int TIMEOUT = 100000,
  parameter int CW      = 17
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ch_in,
  output logic [1:0]    note,
  output logic          note_chg
`ifdef NOTEDET_PERIOD_OUT_EN
  ,
  output logic [CW-1:0] period
`endif
);

  localparam logic [CW-1:0] LO0     = CW'(N0 - TOL);
  localparam logic [CW-1:0] HI0     = CW'(N0 + TOL);
  localparam logic [CW-1:0] LO1     = CW'(N1 - TOL);
  localparam logic [CW-1:0] HI1     = CW'(N1 + TOL);
  localparam logic [CW-1:0] LO2     = CW'(N2 - TOL);
  localparam logic [CW-1:0] HI2     = CW'(N2 + TOL);
  localparam logic [CW-1:0] TMO     = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic          edge_pulse;
  logic [CW-1:0] counter, cnt_nxt;
  logic [1:0]    state, state_nxt;
  note_t         cand, cand_nxt, cls, note_nxt;
  logic [1:0]    matchcnt, mc_nxt;
  logic          classify;

  edge_sync u_edge_sync (
    .clk  (clk),
    .rst  (rst),
    .d_in (ch_in),
    .rise (edge_pulse)
  );

  // Later assignments override earlier ones, so the lowest note index wins on overlap.
  always_comb begin
    cls = NOTE_SIL;
    if (counter >= LO2 && counter <= HI2) cls = NOTE_2;
    if (counter >= LO1 && counter <= HI1) cls = NOTE_1;
    if (counter >= LO0 && counter <= HI0) cls = NOTE_0;
  end

  always_comb begin
    cnt_nxt   = counter;
    state_nxt = state;
    cand_nxt  = cand;
    mc_nxt    = matchcnt;
    note_nxt  = note;
    classify  = 1'b0;
    if (edge_pulse) begin
      // Edge wins over a coincident timeout; the edge cycle is cycle 0 of the next period.
      cnt_nxt = CNT_ONE;
      if (state == ST_SILENT) begin
        state_nxt = ST_ARMED;
      end else begin
        state_nxt = ST_TRACK;
        classify  = 1'b1;
        if (cls == cand) begin
          if (matchcnt != 2'd2) mc_nxt = matchcnt + 2'd1;
        end else begin
          cand_nxt = cls;
          mc_nxt   = 2'd1;
        end
        if (mc_nxt == 2'd2) note_nxt = cand_nxt;
      end
    end else if (counter != TMO) begin
      cnt_nxt = counter + CNT_ONE;
      if (cnt_nxt == TMO) begin
        state_nxt = ST_SILENT;
        cand_nxt  = NOTE_SIL;
        mc_nxt    = 2'd0;
        note_nxt  = NOTE_SIL;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      counter  <= '0;
      state    <= ST_SILENT;
      cand     <= NOTE_SIL;
      matchcnt <= 2'd0;
      note     <= NOTE_SIL;
      note_chg <= 1'b0;
    end else begin
      counter  <= cnt_nxt;
      state    <= state_nxt;
      cand     <= cand_nxt;
      matchcnt <= mc_nxt;
      note     <= note_nxt;
      note_chg <= (note_nxt != note);
    end
  end

`ifdef NOTEDET_PERIOD_OUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      period <= '0;
    end else if (classify) begin
      period <= counter;
    end
  end
`endif

endmodule

// File: tb/tb_note_detector.sv
// Directed bench for note_detector with short periods (N0=20, N1=16, N2=12, TOL=1, TIMEOUT=64).
// Also checks the period output when NOTEDET_PERIOD_OUT_EN is defined.
module tb_note_detector;

  logic       clk = 1'b0;
  logic       rst;
  logic       ch_in;
  logic [1:0] note;
  logic       note_chg;
`ifdef NOTEDET_PERIOD_OUT_EN
  logic [6:0] period;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int chg_cnt = 0;
  int chg_cyc = 0;
  int tone_last = 0;
  int base = 0;

  always #5 clk = ~clk;

  note_detector #(
    .N0(20), .N1(16), .N2(12), .TOL(1), .TIMEOUT(64), .CW(7)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ch_in    (ch_in),
    .note     (note),
    .note_chg (note_chg)
`ifdef NOTEDET_PERIOD_OUT_EN
    ,
    .period   (period)
`endif
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Change strobes are sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (note_chg) begin
      chg_cnt <= chg_cnt + 1;
      chg_cyc <= cyc;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // n rising edges spaced per cycles, ending with ch_in low.
  task automatic tone(input int per, input int n);
    for (int i = 0; i < n; i++) begin
      ch_in = 1'b1;
      tone_last = cyc;
      tick(per / 2);
      ch_in = 1'b0;
      tick(per - per / 2);
    end
  endtask

  initial begin
    int first;
    rst = 1'b1;
    ch_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("rst_note", note, 3);
      check("rst_chg", note_chg, 0);
    end
    rst = 1'b0;
    tick(1);
`ifdef NOTEDET_PERIOD_OUT_EN
    check("rst_period", period, 0);
`endif

    // Period 20: note 0 one cycle after the third edge pulse.
    base = chg_cnt;
    tone(20, 1);
    first = tone_last;
    tone(20, 4);
    check("p20_note", note, 0);
    check("p20_nchg", chg_cnt - base, 1);
    check("p20_chgcyc", chg_cyc, first + 43);

    // Switch to period 12: holds 0 for one period, then 2.
    base = chg_cnt;
    tone(12, 2);
    check("p12_hold", note, 0);
    tone(12, 1);
    check("p12_note", note, 2);
    check("p12_nchg", chg_cnt - base, 1);
    check("p12_chgcyc", chg_cyc, tone_last + 3);

    // Back to 0, then period 13 (inside the window) behaves as 12.
    tone(20, 3);
    check("back20_note", note, 0);
    base = chg_cnt;
    tone(13, 3);
    check("p13_note", note, 2);
    check("p13_nchg", chg_cnt - base, 1);
    check("p13_chgcyc", chg_cyc, tone_last + 3);

    // Period 16 then silence: 1 -> 3 sixty-four cycles after the last edge pulse.
    tone(16, 3);
    check("p16_note", note, 1);
    base = chg_cnt;
    tick(80);
    check("tmo_note", note, 3);
    check("tmo_nchg", chg_cnt - base, 1);
    check("tmo_chgcyc", chg_cyc, tone_last + 66);

    // Unknown period 18 after note 0.
    tone(20, 3);
    check("re20_note", note, 0);
    base = chg_cnt;
    tone(18, 3);
    check("p18_note", note, 3);
    check("p18_nchg", chg_cnt - base, 1);
    check("p18_chgcyc", chg_cyc, tone_last + 3);

    // Alternating 20/18 never settles and never re-pulses.
    tone(20, 3);
    check("alt_pre_note", note, 0);
    base = chg_cnt;
    for (int i = 0; i < 4; i++) begin
      tone(18, 1);
      tone(20, 1);
    end
    check("alt_note", note, 0);
    check("alt_nchg", chg_cnt - base, 0);

    // Reset mid-period while note=1.
    tone(16, 3);
    check("pre_rst_note", note, 1);
    tick(5);
    base = chg_cnt;
    rst = 1'b1;
    tick(1);
    check("mid_rst_note", note, 3);
    check("mid_rst_chg", note_chg, 0);
    rst = 1'b0;
    tick(1);
    check("mid_rst_nchg", chg_cnt - base, 0);
`ifdef NOTEDET_PERIOD_OUT_EN
    check("mid_rst_period", period, 0);
`endif
    tone(16, 2);
    check("rec2_note", note, 3);
`ifdef NOTEDET_PERIOD_OUT_EN
    check("rec_period", period, 16);
`endif
    tone(16, 1);
    check("rec3_note", note, 1);
    check("rec_nchg", chg_cnt - base, 1);
    check("rec_chgcyc", chg_cyc, tone_last + 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
